pac_mp: RTL

//  Parametrised packet action dispatcher between the forwarding (pfw) stage and the buffer manager (ibm) / local ports.
//  Per packet: admission by priority vs free buffer IDs, FAST_MD port rewrite, TSN_MD build, routing to the buffer path and/or one of NUM_LOCAL local ports.
//  A merged monitor copy and statistics counters go to lcm.

---
 rtl/pac_mp_if.sv | 43 ++++
 rtl/pac_mp.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pac_mp_if.sv
// Bundle of the pac_mp datapath, strobes and counters between pfw, ibm, goe-side ports and lcm.
// The slave modport is the dispatcher's view; master is the surrounding environment's view.
interface pac_mp_if #(
  parameter int NUM_LOCAL = 2,
  parameter int IDW       = 5
);
  logic [133:0]             in_data;
  logic                     in_data_wr;
  logic [10:0]              in_action;
  logic [IDW-1:0]           bufm_free;
  logic [133:0]             out_buf_data;
  logic                     out_buf_wr;
  logic                     out_buf_valid;
  logic                     out_buf_vwr;
  logic [23:0]              out_tsn_md;
  logic                     out_tsn_md_wr;
  logic [134*NUM_LOCAL-1:0] out_loc_data;
  logic [NUM_LOCAL-1:0]     out_loc_wr;
  logic [NUM_LOCAL-1:0]     out_loc_vwr;
  logic [133:0]             out_mon_data;
  logic                     out_mon_wr;
  logic                     out_mon_vwr;
  logic [63:0]              pktout_cnt;
  logic [31:0]              drop_cnt;
  logic [15:0]              trunc_cnt;
  logic [15:0]              ping_cnt;

  modport slave (
    input  in_data, in_data_wr, in_action, bufm_free,
    output out_buf_data, out_buf_wr, out_buf_valid, out_buf_vwr,
    output out_tsn_md, out_tsn_md_wr, out_loc_data, out_loc_wr, out_loc_vwr,
    output out_mon_data, out_mon_wr, out_mon_vwr,
    output pktout_cnt, drop_cnt, trunc_cnt, ping_cnt
  );

  modport master (
    output in_data, in_data_wr, in_action, bufm_free,
    input  out_buf_data, out_buf_wr, out_buf_valid, out_buf_vwr,
    input  out_tsn_md, out_tsn_md_wr, out_loc_data, out_loc_wr, out_loc_vwr,
    input  out_mon_data, out_mon_wr, out_mon_vwr,
    input  pktout_cnt, drop_cnt, trunc_cnt, ping_cnt
  );
endinterface

// File: rtl/pac_mp.sv
// Packet action dispatcher: per-packet admission, dest rewrite, TSN metadata, buffer/local routing, monitor merge.
// Optional feature: define PAC_PING_CNT_EN to count ping heads (in_data[71:64]==8'hff) sent to local ports.
module pac_mp #(
  parameter int NUM_LOCAL  = 2,
  parameter int LOCAL_BASE = 2,
  parameter int IDW        = 5,
  parameter int RSV_P0     = 4,
  parameter int RSV_P1     = 3
) (
  input  logic     clk,
  input  logic     rst_n,
  pac_mp_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, TRANS, DISC} state_t;

  state_t state_q, state_d;

  logic [133:0] in_data;
  logic [10:0]  in_action;
  logic [1:0]   mode;
  logic [2:0]   prio;
  logic [5:0]   dest;
  logic         is_head, is_tail, admit, local_hit;
  logic [NUM_LOCAL-1:0] hit_vec;

  logic                 pkt_buf_q, pkt_buf_d;
  logic [NUM_LOCAL-1:0] pkt_loc_q, pkt_loc_d;

  logic                 s1_vld_q, s1_vld_d, s1_buf_q, s1_buf_d;
  logic                 s1_head_q, s1_head_d, s1_tail_q, s1_tail_d;
  logic [NUM_LOCAL-1:0] s1_loc_q, s1_loc_d;
  logic [133:0]         s1_data_q, s1_data_d;
  logic [23:0]          s1_md_q, s1_md_d;

  logic         drop_inc, trunc_inc;
  logic [133:0] buf_data_q;
  logic         buf_wr_q, buf_vwr_q, md_wr_q;
  logic [23:0]  md_q;

  logic [NUM_LOCAL-1:0] loc_wr_vec, loc_vwr_vec;
  logic [133:0]         mon_or [NUM_LOCAL+1];
  logic                 loc_any, mon_wr_d, mon_vwr_d;
  logic [133:0]         mon_data_d, mon_data_q;
  logic                 mon_wr_q, mon_vwr_q;

  logic [63:0] pktout_q;
  logic [31:0] drop_q;
  logic [15:0] trunc_q;

  assign in_data   = bus.in_data;
  assign in_action = bus.in_action;
  assign mode      = in_action[10:9];
  assign prio      = in_action[8:6];
  assign dest      = in_action[5:0];
  assign is_head   = (in_data[133:132] == 2'b01);
  assign is_tail   = (in_data[133:132] == 2'b10);
  assign local_hit = |hit_vec;

  assign admit = (prio == 3'd0) ? (bus.bufm_free >= IDW'(RSV_P0)) :
                 (prio == 3'd1) ? (bus.bufm_free >= IDW'(RSV_P1)) :
                                  (bus.bufm_free != '0);

`ifdef PAC_PING_CNT_EN
  logic        ping_inc;
  logic [15:0] ping_q;
`endif

  // Decision is taken only on a head flit and frozen in pkt_*_q for the remainder of the packet.
  always_comb begin
    state_d   = state_q;
    pkt_buf_d = pkt_buf_q;
    pkt_loc_d = pkt_loc_q;
    s1_vld_d  = 1'b0;
    s1_buf_d  = 1'b0;
    s1_loc_d  = '0;
    s1_head_d = 1'b0;
    s1_tail_d = 1'b0;
    s1_data_d = in_data;
    s1_md_d   = {prio, in_data[107:96], in_action[0], 8'h00};
    drop_inc  = 1'b0;
    trunc_inc = 1'b0;
`ifdef PAC_PING_CNT_EN
    ping_inc  = 1'b0;
`endif
    if (bus.in_data_wr) begin
      if (is_head) begin
        trunc_inc = (state_q != IDLE);
        s1_data_d[117:112] = dest;
        if (mode == 2'b10) begin
          pkt_buf_d = admit;
          pkt_loc_d = NUM_LOCAL'(1);
          drop_inc  = ~admit;
        end else if (local_hit) begin
          pkt_buf_d = 1'b0;
          pkt_loc_d = hit_vec;
        end else begin
          pkt_buf_d = admit;
          pkt_loc_d = '0;
        end
        state_d   = (pkt_buf_d || (|pkt_loc_d)) ? TRANS : DISC;
        s1_vld_d  = 1'b1;
        s1_head_d = 1'b1;
        s1_buf_d  = pkt_buf_d;
        s1_loc_d  = pkt_loc_d;
`ifdef PAC_PING_CNT_EN
        ping_inc  = (|pkt_loc_d) && (in_data[71:64] == 8'hff);
`endif
      end else if (state_q == TRANS) begin
        s1_vld_d  = 1'b1;
        s1_buf_d  = pkt_buf_q;
        s1_loc_d  = pkt_loc_q;
        s1_tail_d = is_tail;
        if (is_tail) state_d = IDLE;
      end else if (state_q == DISC) begin
        if (is_tail) begin
          drop_inc = 1'b1;
          state_d  = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pkt_buf_q  <= 1'b0;
      pkt_loc_q  <= '0;
      s1_vld_q   <= 1'b0;
      s1_buf_q   <= 1'b0;
      s1_loc_q   <= '0;
      s1_head_q  <= 1'b0;
      s1_tail_q  <= 1'b0;
      s1_data_q  <= '0;
      s1_md_q    <= '0;
      buf_data_q <= '0;
      buf_wr_q   <= 1'b0;
      buf_vwr_q  <= 1'b0;
      md_wr_q    <= 1'b0;
      md_q       <= '0;
      mon_data_q <= '0;
      mon_wr_q   <= 1'b0;
      mon_vwr_q  <= 1'b0;
      pktout_q   <= '0;
      drop_q     <= '0;
      trunc_q    <= '0;
    end else begin
      state_q    <= state_d;
      pkt_buf_q  <= pkt_buf_d;
      pkt_loc_q  <= pkt_loc_d;
      s1_vld_q   <= s1_vld_d;
      s1_buf_q   <= s1_buf_d;
      s1_loc_q   <= s1_loc_d;
      s1_head_q  <= s1_head_d;
      s1_tail_q  <= s1_tail_d;
      s1_data_q  <= s1_data_d;
      s1_md_q    <= s1_md_d;
      buf_wr_q   <= s1_vld_q & s1_buf_q;
      buf_vwr_q  <= s1_vld_q & s1_buf_q & s1_tail_q;
      md_wr_q    <= s1_vld_q & s1_buf_q & s1_head_q;
      if (s1_vld_q && s1_buf_q) buf_data_q <= s1_data_q;
      if (s1_vld_q && s1_buf_q && s1_head_q) md_q <= s1_md_q;
      mon_wr_q   <= mon_wr_d;
      mon_vwr_q  <= mon_vwr_d;
      if (mon_wr_d) mon_data_q <= mon_data_d;
      pktout_q   <= pktout_q + 64'(mon_vwr_q);
      drop_q     <= drop_q + 32'(drop_inc);
      trunc_q    <= trunc_q + 16'(trunc_inc);
    end
  end

  assign mon_or[0] = '0;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LOCAL; gi++) begin : g_loc
      logic [133:0] data_q;
      logic         wr_q, vwr_q;

      assign hit_vec[gi] = ({1'b0, dest} == 7'(LOCAL_BASE + gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_q <= '0;
          wr_q   <= 1'b0;
          vwr_q  <= 1'b0;
        end else begin
          wr_q  <= s1_vld_q & s1_loc_q[gi];
          vwr_q <= s1_vld_q & s1_loc_q[gi] & s1_tail_q;
          if (s1_vld_q && s1_loc_q[gi]) data_q <= s1_data_q;
        end
      end

      assign bus.out_loc_data[134*gi +: 134] = data_q;
      assign loc_wr_vec[gi]  = wr_q;
      assign loc_vwr_vec[gi] = vwr_q;
      // At most one local port is active per cycle, so an AND-OR chain selects it.
      assign mon_or[gi+1] = mon_or[gi] | (wr_q ? data_q : 134'd0);
    end
  endgenerate

  // Local copy wins the monitor when it coincides with a buffer-path flit.
  assign loc_any    = |loc_wr_vec;
  assign mon_wr_d   = loc_any | buf_wr_q;
  assign mon_vwr_d  = loc_any ? (|loc_vwr_vec) : buf_vwr_q;
  assign mon_data_d = loc_any ? mon_or[NUM_LOCAL] : buf_data_q;

`ifdef PAC_PING_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ping_q <= '0;
    else        ping_q <= ping_q + 16'(ping_inc);
  end
  assign bus.ping_cnt = ping_q;
`else
  assign bus.ping_cnt = 16'h0;
`endif

  assign bus.out_buf_data  = buf_data_q;
  assign bus.out_buf_wr    = buf_wr_q;
  assign bus.out_buf_valid = buf_vwr_q;
  assign bus.out_buf_vwr   = buf_vwr_q;
  assign bus.out_tsn_md    = md_q;
  assign bus.out_tsn_md_wr = md_wr_q;
  assign bus.out_loc_wr    = loc_wr_vec;
  assign bus.out_loc_vwr   = loc_vwr_vec;
  assign bus.out_mon_data  = mon_data_q;
  assign bus.out_mon_wr    = mon_wr_q;
  assign bus.out_mon_vwr   = mon_vwr_q;
  assign bus.pktout_cnt    = pktout_q;
  assign bus.drop_cnt      = drop_q;
  assign bus.trunc_cnt     = trunc_q;

endmodule
